// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low patterns {a,b,c,d,e,f,g} for
// hex digits 0..F, the blank pattern, and the scan-encoder state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001101;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0000010;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } seg_state_e;

endpackage

// File: rtl/seg_pattern_lut.sv
// Combinational inverse of the hex-to-segment decoder: maps an active-low
// segment pattern to its hex value, with o_hit low for unknown patterns.
module seg_pattern_lut
  import seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_val,
  output logic       o_hit
);

  // Pattern lookup; anything outside the table reports a miss with value 0.
  always_comb begin
    o_val = 4'h0;
    o_hit = 1'b1;
    case (i_seg)
      SEG_0:   o_val = 4'h0;
      SEG_1:   o_val = 4'h1;
      SEG_2:   o_val = 4'h2;
      SEG_3:   o_val = 4'h3;
      SEG_4:   o_val = 4'h4;
      SEG_5:   o_val = 4'h5;
      SEG_6:   o_val = 4'h6;
      SEG_7:   o_val = 4'h7;
      SEG_8:   o_val = 4'h8;
      SEG_9:   o_val = 4'h9;
      SEG_A:   o_val = 4'hA;
      SEG_B:   o_val = 4'hB;
      SEG_C:   o_val = 4'hC;
      SEG_D:   o_val = 4'hD;
      SEG_E:   o_val = 4'hE;
      SEG_F:   o_val = 4'hF;
      default: begin
        o_val = 4'h0;
        o_hit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_encoder.sv
// Loopback monitor for a multiplexed active-low seven-segment bus: waits for a
// stable anode/segment pair, decodes it and stores the value per digit.
module seg_scan_encoder
  import seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  capture_valid,
  output logic [2:0]            capture_idx,
  output logic [3:0]            capture_val,
  output logic                  pattern_err,
  output logic                  anode_err,
  output logic                  frame_done
);

  localparam int         SW         = DIGITS + 7;
  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] EVAL_CNT   = 8'(STABLE_CYCLES - 1);

  logic [SW-1:0]       w_in;
  logic [SW-1:0]       r_sample;
  logic [7:0]          r_cnt;
  logic                w_same;
  logic [DIGITS-1:0]   w_low;
  logic                w_blank;
  logic                w_one_hot;
  logic [2:0]          w_idx;
  logic [3:0]          w_val;
  logic                w_hit;
  seg_state_e          r_state;
  seg_state_e          w_next;
  logic                w_cap;
  logic                w_perr;
  logic                w_aerr;

  logic [4*DIGITS-1:0] r_digits;
  logic [DIGITS-1:0]   r_digit_valid;
  logic                r_capture_valid;
  logic [2:0]          r_capture_idx;
  logic [3:0]          r_capture_val;
  logic                r_pattern_err;
  logic                r_anode_err;
  logic                r_frame_done;

  assign w_in      = {an, seg};
  assign w_same    = (w_in == r_sample);
  assign w_low     = ~r_sample[SW-1:7];
  assign w_blank   = (w_low == {DIGITS{1'b0}});
  assign w_one_hot = !w_blank &&
                     ((w_low & (w_low - {{(DIGITS-1){1'b0}}, 1'b1})) == {DIGITS{1'b0}});

  seg_pattern_lut u_lut (
    .i_seg (r_sample[6:0]),
    .o_val (w_val),
    .o_hit (w_hit)
  );

  // Index of the single low anode; only meaningful when w_one_hot is set.
  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      w_idx = w_idx | (w_low[i] ? 3'(i) : 3'd0);
    end
  end

  // Sample register and saturating stability counter (reset to blank, count 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample <= {SW{1'b1}};
      r_cnt    <= 8'd0;
    end else begin
      r_sample <= w_in;
      if (!w_same) begin
        r_cnt <= 8'd0;
      end else if (r_cnt < STABLE_MAX) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and one-shot evaluation; r_cnt == 0 means the sample just changed.
  always_comb begin
    w_next = r_state;
    w_cap  = 1'b0;
    w_perr = 1'b0;
    w_aerr = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_blank) begin
          w_next = SETTLE;
        end else begin
          w_next = IDLE;
        end
      end
      SETTLE: begin
        if ((r_cnt == 8'd0) && w_blank) begin
          w_next = IDLE;
        end else if ((r_cnt == EVAL_CNT) && w_same) begin
          w_next = HELD;
          if (w_blank) begin
            w_next = IDLE;
          end else if (!w_one_hot) begin
            w_aerr = 1'b1;
          end else if (w_hit) begin
            w_cap = 1'b1;
          end else begin
            w_perr = 1'b1;
          end
        end else begin
          w_next = SETTLE;
        end
      end
      HELD: begin
        if (r_cnt == 8'd0) begin
          w_next = w_blank ? IDLE : SETTLE;
        end else begin
          w_next = HELD;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Registered results: digit store, frame tracking and event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits        <= {(4*DIGITS){1'b0}};
      r_digit_valid   <= {DIGITS{1'b0}};
      r_capture_valid <= 1'b0;
      r_capture_idx   <= 3'd0;
      r_capture_val   <= 4'h0;
      r_pattern_err   <= 1'b0;
      r_anode_err     <= 1'b0;
      r_frame_done    <= 1'b0;
    end else begin
      r_capture_valid <= w_cap;
      r_pattern_err   <= w_perr;
      r_anode_err     <= w_aerr;
      r_frame_done    <= 1'b0;
      if (w_cap) begin
        r_capture_idx <= w_idx;
        r_capture_val <= w_val;
      end
      for (int i = 0; i < DIGITS; i++) begin
        if (w_cap && (w_idx == 3'(i))) begin
          r_digits[4*i +: 4] <= w_val;
        end
      end
      if (&r_digit_valid) begin
        r_frame_done  <= 1'b1;
        r_digit_valid <= {DIGITS{1'b0}};
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          if (w_cap && (w_idx == 3'(i))) begin
            r_digit_valid[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign digits        = r_digits;
  assign digit_valid   = r_digit_valid;
  assign capture_valid = r_capture_valid;
  assign capture_idx   = r_capture_idx;
  assign capture_val   = r_capture_val;
  assign pattern_err   = r_pattern_err;
  assign anode_err     = r_anode_err;
  assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_seg_scan_encoder.sv
// Directed bench for seg_scan_encoder (DIGITS=4, STABLE_CYCLES=4): latency,
// full frame scan, pattern and anode errors, glitch rejection, mid-window reset.
module tb_seg_scan_encoder;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        capture_valid;
  logic [2:0]  capture_idx;
  logic [3:0]  capture_val;
  logic        pattern_err;
  logic        anode_err;
  logic        frame_done;

  int n_checks;
  int n_fail;
  int n_cap;
  int n_perr;
  int n_aerr;
  int n_frame;

  seg_scan_encoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seg           (seg),
    .an            (an),
    .digits        (digits),
    .digit_valid   (digit_valid),
    .capture_valid (capture_valid),
    .capture_idx   (capture_idx),
    .capture_val   (capture_val),
    .pattern_err   (pattern_err),
    .anode_err     (anode_err),
    .frame_done    (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_counts;
    n_cap = 0; n_perr = 0; n_aerr = 0; n_frame = 0;
  endtask

  // One rising edge, then sample on the following falling edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    if (capture_valid) n_cap++;
    if (pattern_err)   n_perr++;
    if (anode_err)     n_aerr++;
    if (frame_done)    n_frame++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; an = 4'b1111; seg = 7'b1111111;
    repeat (2) @(negedge clk);
    n_checks++;
    if (digits !== 16'h0000) begin n_fail++; $display("FAIL reset_digits: got %h want 0000", digits); end
    n_checks++;
    if (digit_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b want 0000", digit_valid); end
    n_checks++;
    if ({capture_valid, pattern_err, anode_err, frame_done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 0000", {capture_valid, pattern_err, anode_err, frame_done});
    end
    n_checks++;
    if ({capture_idx, capture_val} !== 7'd0) begin
      n_fail++; $display("FAIL reset_idx_val: got idx=%0d val=%h want 0/0", capture_idx, capture_val);
    end
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_latency;
    clear_counts();
    an = 4'b1110; seg = 7'b0010010;
    repeat (4) tick();
    n_checks++;
    if (capture_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early: capture_valid=%b want 0", capture_valid); end
    tick();
    n_checks++;
    if (capture_valid !== 1'b1) begin n_fail++; $display("FAIL lat_fire: capture_valid=%b want 1", capture_valid); end
    n_checks++;
    if (capture_idx !== 3'd0 || capture_val !== 4'h2) begin
      n_fail++; $display("FAIL lat_data: idx=%0d val=%h want 0/2", capture_idx, capture_val);
    end
    n_checks++;
    if (digits[3:0] !== 4'h2 || digit_valid !== 4'b0001) begin
      n_fail++; $display("FAIL lat_store: digit0=%h valid=%b want 2/0001", digits[3:0], digit_valid);
    end
    repeat (10) tick();
    n_checks++;
    if (n_cap !== 1) begin n_fail++; $display("FAIL lat_once: captures=%0d want 1", n_cap); end
  endtask

  task automatic test_frame;
    logic [6:0] pats [4];
    logic [3:0] vals [4];
    logic [3:0] a;
    pats[0] = 7'b0000110; vals[0] = 4'h3;
    pats[1] = 7'b0001101; vals[1] = 4'h7;
    pats[2] = 7'b0110001; vals[2] = 4'hC;
    pats[3] = 7'b0111000; vals[3] = 4'hF;
    clear_counts();
    for (int d = 0; d < 4; d++) begin
      a = 4'b1111;
      a[d] = 1'b0;
      an = a; seg = pats[d];
      for (int j = 1; j <= 6; j++) begin
        tick();
        if (j == 5) begin
          n_checks++;
          if (capture_valid !== 1'b1 || capture_idx !== 3'(d) || capture_val !== vals[d]) begin
            n_fail++;
            $display("FAIL frame_cap%0d: valid=%b idx=%0d val=%h want 1/%0d/%h",
                     d, capture_valid, capture_idx, capture_val, d, vals[d]);
          end
        end
        if (d == 2 && j == 6) begin
          n_checks++;
          if (digit_valid !== 4'b0111) begin n_fail++; $display("FAIL frame_partial: valid=%b want 0111", digit_valid); end
        end
        if (d == 3 && j == 6) begin
          n_checks++;
          if (frame_done !== 1'b1 || digit_valid !== 4'b0000) begin
            n_fail++; $display("FAIL frame_done: done=%b valid=%b want 1/0000", frame_done, digit_valid);
          end
        end
      end
    end
    n_checks++;
    if (digits !== 16'hFC73) begin n_fail++; $display("FAIL frame_digits: got %h want FC73", digits); end
    n_checks++;
    if (n_frame !== 1 || n_cap !== 4) begin
      n_fail++; $display("FAIL frame_counts: frames=%0d caps=%0d want 1/4", n_frame, n_cap);
    end
  endtask

  task automatic test_pattern_err;
    clear_counts();
    an = 4'b1101; seg = 7'b1111110;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j == 5) begin
        n_checks++;
        if (pattern_err !== 1'b1) begin n_fail++; $display("FAIL perr_fire: pattern_err=%b want 1", pattern_err); end
      end
    end
    n_checks++;
    if (n_perr !== 1 || n_cap !== 0) begin
      n_fail++; $display("FAIL perr_counts: perr=%0d caps=%0d want 1/0", n_perr, n_cap);
    end
    n_checks++;
    if (digits !== 16'hFC73 || digit_valid !== 4'b0000) begin
      n_fail++; $display("FAIL perr_state: digits=%h valid=%b want FC73/0000", digits, digit_valid);
    end
  endtask

  task automatic test_anode_err;
    clear_counts();
    an = 4'b1100; seg = 7'b0000001;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j == 5) begin
        n_checks++;
        if (anode_err !== 1'b1) begin n_fail++; $display("FAIL aerr_fire: anode_err=%b want 1", anode_err); end
      end
    end
    n_checks++;
    if (n_aerr !== 1 || n_cap !== 0 || n_perr !== 0) begin
      n_fail++; $display("FAIL aerr_counts: aerr=%0d caps=%0d perr=%0d want 1/0/0", n_aerr, n_cap, n_perr);
    end
    n_checks++;
    if (digits !== 16'hFC73) begin n_fail++; $display("FAIL aerr_digits: got %h want FC73", digits); end
  endtask

  task automatic test_glitch_reset;
    clear_counts();
    an = 4'b1110;
    for (int t = 0; t < 6; t++) begin
      seg = (t % 2 == 0) ? 7'b0100100 : 7'b0100000;
      repeat (3) tick();
    end
    n_checks++;
    if ((n_cap + n_perr + n_aerr + n_frame) !== 0) begin
      n_fail++; $display("FAIL glitch_quiet: caps=%0d perr=%0d aerr=%0d frames=%0d want 0", n_cap, n_perr, n_aerr, n_frame);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (digits !== 16'h0000 || digit_valid !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid_store: digits=%h valid=%b want 0000/0000", digits, digit_valid);
    end
    n_checks++;
    if ({capture_valid, pattern_err, anode_err, frame_done, capture_idx, capture_val} !== 11'd0) begin
      n_fail++; $display("FAIL rst_mid_out: idx=%0d val=%h pulses=%b want 0", capture_idx, capture_val,
                         {capture_valid, pattern_err, anode_err, frame_done});
    end
    rst_n = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (capture_valid !== 1'b0 || digit_valid !== 4'b0000) begin
      n_fail++; $display("FAIL rewindow_early: valid=%b dv=%b want 0/0000", capture_valid, digit_valid);
    end
    tick();
    n_checks++;
    if (capture_valid !== 1'b1 || capture_val !== 4'h6 || capture_idx !== 3'd0 || digit_valid !== 4'b0001) begin
      n_fail++; $display("FAIL rewindow_fire: valid=%b val=%h idx=%0d dv=%b want 1/6/0/0001",
                         capture_valid, capture_val, capture_idx, digit_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_counts();
    test_reset();
    test_latency();
    test_frame();
    test_pattern_err();
    test_anode_err();
    test_glitch_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_encoder.md
# seg_scan_encoder

Recovers hex digit values from a multiplexed, active-low seven-segment display bus by watching the segment lines and digit anodes. It is the inverse of our hex-to-segment decoder and sits on the display side as a loopback monitor, so self-test logic can read back what the display is actually showing. The block waits for each anode and segment pair to hold stable, encodes the pattern to a 4-bit value, and stores it per digit. It flags patterns and anode states it cannot interpret.

## Interface
- DIGITS, 4: number of multiplexed digits (2..8).
- STABLE_CYCLES, 4: consecutive identical samples required before capture (2..255).
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low; one clock, no other reset.
- seg  in  7  segment lines, active-low, {a,b,c,d,e,f,g} = seg[6:0].
- an  in  DIGITS  digit enables, active-low.
- digits  out  4*DIGITS  last captured value per digit; digit i is at [4i+3:4i].
- digit_valid  out  DIGITS  digit i captured since reset or since the last frame_done.
- capture_valid  out  1  one-cycle pulse marking a new capture.
- capture_idx  out  3  digit index of the capture.
- capture_val  out  4  value of the capture.
- pattern_err  out  1  one-cycle pulse: a stable pattern is not in the table.
- anode_err  out  1  one-cycle pulse: more than one anode is low and stable.
- frame_done  out  1  one-cycle pulse: all DIGITS digits have been captured.

## Operation
- Encoding table (seg[6:0] -> value):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3
  - 1001100->4, 0100100->5, 0100000->6, 0001101->7
  - 0000000->8, 0000100->9, 0000010->A, 1100000->B
  - 0110001->C, 1000010->D, 0110000->E, 0111000->F
- Input stage: {an, seg} is registered every cycle into the sample register. The stability counter clears to 0 when the sample differs from the previous sample; otherwise it increments and saturates at STABLE_CYCLES.
- The state machine has three states: IDLE, SETTLE and HELD.
  - IDLE: all anodes high (blank). Go to SETTLE on any anode low.
  - SETTLE: counting. When the counter reaches STABLE_CYCLES-1 on an unchanged sample, evaluate the sample and go to HELD.
    - Exactly one anode low and the pattern is in the table: capture.
    - Exactly one anode low and the pattern is not in the table: pattern_err.
    - More than one anode low: anode_err.
  - HELD: no further action. Go back to SETTLE on any sample change, or to IDLE on blank.
- Capture: write digits[idx], set digit_valid[idx], and pulse capture_valid with capture_idx and capture_val.
- Each stable window produces at most one capture or one error. A pattern held for a long time never re-fires.
- frame_done fires in the cycle after the capture that makes digit_valid all ones. In that same cycle digit_valid clears to 0. digits keeps its contents.
- A stable pattern on an already-valid digit overwrites that digit and does not advance the frame.
- On pattern_err or anode_err, digits and digit_valid do not change.

## Timing
- Reset values: digits = 0, digit_valid = 0, all pulses = 0, capture_idx = 0, capture_val = 0, state = IDLE, counter = 0.
- Latency: when new inputs are present at edge k, capture_valid (or an error pulse) is high in the cycle after edge k+STABLE_CYCLES. digits updates at that same edge.
- An input glitch of any length shorter than STABLE_CYCLES produces no capture and no error.
- Reset asserted mid-window returns everything to the reset values immediately. After release, a full stable window is required again.
- capture_idx width is fixed at 3. Bits above log2(DIGITS) are 0.

## Structure
- Package seg_pkg holds:
  - the 16 pattern constants (shared with the decoder);
  - the SEG_BLANK = 7'b1111111 constant;
  - the state enum.
- Sub-module seg_pattern_lut is a combinational 7-to-4 encoder with a hit flag. It is instantiated once, on the sample register.

## Test plan
- Hold an=1110, seg=0010010 with STABLE_CYCLES=4. capture_valid fires once with idx=0 and val=2, at the latency given in Timing, then stays low while the inputs are held.
- Scan the four digits in turn with values 3, 7, C, F, each held for 6 cycles. Expect digits=16'hFC73 and a frame_done pulse one cycle after the fourth capture, with digit_valid=0 in that cycle.
- Hold seg=1111110 with an=1101 stable. pattern_err pulses once, and digits and digit_valid are unchanged.
- Hold an=1100 stable. anode_err pulses once and there is no capture.
- Toggle seg between patterns every 3 cycles with STABLE_CYCLES=4. Expect no pulses at all. Then assert rst_n low at SETTLE count 2: all outputs read 0 on the next cycle.
